// File: rtl/sd_cmd_sequencer_pkg.sv
// Shared state encoding and default frame/response sizes for the SD CMD-line sequencer,
// its serializer/deserializer and the bit counter.
package sd_cmd_sequencer_pkg;

  localparam int unsigned FRAME_BITS_DEF  = 38;
  localparam int unsigned RESP_BITS_DEF   = 32;
  localparam int unsigned TURN_CYCLES_DEF = 2;
  localparam int unsigned TIMEOUT_DEF     = 64;
  localparam int unsigned CNT_W_DEF       = 8;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    SEND      = 3'd1,
    TURN      = 3'd2,
    WAIT_RESP = 3'd3,
    RECEIVE   = 3'd4,
    DONE      = 3'd5
  } seqState_t;

endpackage

// File: rtl/sd_bit_counter.sv
// Loadable down-counter with enable and a registered zero flag; it stops at zero instead of wrapping.
module sd_bit_counter #(
  parameter int unsigned CNT_W = 8
) (
  input  logic             iSD_clock,
  input  logic             iReset,
  input  logic             enable,
  input  logic             load,
  input  logic [CNT_W-1:0] loadValue,
  output logic             zero
);

  logic [CNT_W-1:0] count;

  always_ff @(posedge iSD_clock or negedge iReset) begin
    if (!iReset) begin
      count <= '0;
      zero  <= 1'b1;
    end else if (enable) begin
      if (load) begin
        count <= loadValue;
        zero  <= (loadValue == '0);
      end else if (!zero) begin
        count <= count - CNT_W'(1);
        zero  <= (count == CNT_W'(1));
      end
    end
  end

endmodule

// File: rtl/sd_cmd_sequencer.sv
// Runs one SD command transaction on the CMD line: serial send, line turnaround,
// start-bit hunt with timeout, and parallel response capture.
module sd_cmd_sequencer
  import sd_cmd_sequencer_pkg::*;
#(
  parameter int unsigned FRAME_BITS  = FRAME_BITS_DEF,
  parameter int unsigned RESP_BITS   = RESP_BITS_DEF,
  parameter int unsigned TURN_CYCLES = TURN_CYCLES_DEF,
  parameter int unsigned TIMEOUT     = TIMEOUT_DEF,
  parameter int unsigned CNT_W       = CNT_W_DEF
) (
  input  logic                  iSD_clock,
  input  logic                  iReset,
  input  logic                  iEnable,
  input  logic                  iStart,
  input  logic                  iResp_expected,
  input  logic [FRAME_BITS-1:0] iParallel,
  input  logic                  iSerial,
  output logic                  oSerial,
  output logic                  oOutput_enable,
  output logic                  oBusy,
  output logic                  oComplete,
  output logic                  oTimeout,
  output logic [RESP_BITS-1:0]  oResponse
);

  seqState_t             state;
  logic [FRAME_BITS-1:0] frameReg;
  logic                  respExpected;
  logic                  cntLoad;
  logic [CNT_W-1:0]      cntLoadValue;
  logic                  cntZero;

  // Counter reload on each state entry; the loaded value is the cycles remaining after this one.
  always_comb begin
    cntLoad      = 1'b0;
    cntLoadValue = '0;
    case (state)
      IDLE: if (iStart) begin
        cntLoad      = 1'b1;
        cntLoadValue = CNT_W'(FRAME_BITS - 1);
      end
      SEND: if (cntZero && respExpected) begin
        cntLoad      = 1'b1;
        cntLoadValue = CNT_W'(TURN_CYCLES - 1);
      end
      TURN: if (cntZero) begin
        cntLoad      = 1'b1;
        cntLoadValue = CNT_W'(TIMEOUT - 1);
      end
      WAIT_RESP: if (!iSerial) begin
        cntLoad      = 1'b1;
        cntLoadValue = CNT_W'(RESP_BITS - 1);
      end
      default: ;
    endcase
  end

  sd_bit_counter #(.CNT_W(CNT_W)) bitCounter (
    .iSD_clock (iSD_clock),
    .iReset    (iReset),
    .enable    (iEnable),
    .load      (cntLoad),
    .loadValue (cntLoadValue),
    .zero      (cntZero)
  );

  always_ff @(posedge iSD_clock or negedge iReset) begin
    if (!iReset) begin
      state          <= IDLE;
      frameReg       <= '0;
      respExpected   <= 1'b0;
      oSerial        <= 1'b1;
      oOutput_enable <= 1'b0;
      oBusy          <= 1'b0;
      oComplete      <= 1'b0;
      oTimeout       <= 1'b0;
      oResponse      <= '0;
    end else if (iEnable) begin
      oComplete <= 1'b0;
      case (state)
        IDLE: begin
          oSerial        <= 1'b1;
          oOutput_enable <= 1'b0;
          if (iStart) begin
            // MSB goes out right away; the register keeps the bits still to send.
            frameReg       <= iParallel << 1;
            oSerial        <= iParallel[FRAME_BITS-1];
            oOutput_enable <= 1'b1;
            respExpected   <= iResp_expected;
            oTimeout       <= 1'b0;
            oBusy          <= 1'b1;
            state          <= SEND;
          end
        end
        SEND: begin
          if (cntZero) begin
            oSerial        <= 1'b1;
            oOutput_enable <= 1'b0;
            if (respExpected) begin
              state <= TURN;
            end else begin
              oComplete <= 1'b1;
              state     <= DONE;
            end
          end else begin
            oSerial  <= frameReg[FRAME_BITS-1];
            frameReg <= frameReg << 1;
          end
        end
        TURN: begin
          if (cntZero) state <= WAIT_RESP;
        end
        WAIT_RESP: begin
          if (!iSerial) begin
            state <= RECEIVE;
          end else if (cntZero) begin
            oTimeout  <= 1'b1;
            oComplete <= 1'b1;
            state     <= DONE;
          end
        end
        RECEIVE: begin
          oResponse <= {oResponse[RESP_BITS-2:0], iSerial};
          if (cntZero) begin
            oComplete <= 1'b1;
            state     <= DONE;
          end
        end
        DONE: begin
          oBusy <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sd_cmd_sequencer.sv
// Scoreboard bench for sd_cmd_sequencer: stimulus queues expected serial bits and
// completion records; a negedge monitor pops and compares them as the DUT presents them.
module tb_sd_cmd_sequencer;

  localparam int FB = 38;
  localparam int RB = 32;

  logic          iSD_clock = 1'b0;
  logic          iReset;
  logic          iEnable;
  logic          iStart;
  logic          iResp_expected;
  logic [FB-1:0] iParallel;
  logic          iSerial;
  logic          oSerial;
  logic          oOutput_enable;
  logic          oBusy;
  logic          oComplete;
  logic          oTimeout;
  logic [RB-1:0] oResponse;

  sd_cmd_sequencer dut (
    .iSD_clock      (iSD_clock),
    .iReset         (iReset),
    .iEnable        (iEnable),
    .iStart         (iStart),
    .iResp_expected (iResp_expected),
    .iParallel      (iParallel),
    .iSerial        (iSerial),
    .oSerial        (oSerial),
    .oOutput_enable (oOutput_enable),
    .oBusy          (oBusy),
    .oComplete      (oComplete),
    .oTimeout       (oTimeout),
    .oResponse      (oResponse)
  );

  always #5 iSD_clock = ~iSD_clock;

  int cyc = 0;
  always @(posedge iSD_clock) cyc <= cyc + 1;

  int nChecks = 0;
  int nFails  = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    nChecks++;
    if (act !== exp) begin
      nFails++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  typedef struct {
    logic [RB-1:0] resp;
    logic          tout;
    int            cycle;
  } done_t;

  done_t sbDone[$];
  logic  sbBit[$];
  logic  checkIdleNext = 1'b0;

  // Monitor: serial bits while driving, completion record on oComplete.
  always @(negedge iSD_clock) begin
    if (checkIdleNext) begin
      check("complete_width", oComplete, 0);
      check("busy_after_done", oBusy, 0);
      checkIdleNext = 1'b0;
    end
    if (iReset && oOutput_enable) begin
      check("serial_expected", sbBit.size() != 0, 1);
      if (sbBit.size() != 0) check("serial_bit", oSerial, sbBit.pop_front());
    end else begin
      check("serial_released_high", oSerial, 1);
    end
    if (iReset && oComplete) begin
      check("complete_expected", sbDone.size() != 0, 1);
      if (sbDone.size() != 0) begin
        done_t e;
        e = sbDone.pop_front();
        check("response", oResponse, e.resp);
        check("timeout_flag", oTimeout, e.tout);
        check("complete_cycle", cyc, e.cycle);
        check("busy_in_done", oBusy, 1);
        checkIdleNext = 1'b1;
      end
    end
  end

  task automatic tick();
    @(negedge iSD_clock);
  endtask

  task automatic wait_cyc(input int c);
    while (cyc < c) tick();
  endtask

  // Called at a negedge in IDLE; returns the number of the accepting posedge.
  task automatic start_cmd(input logic [FB-1:0] frame, input logic resp, output int acc);
    iParallel      = frame;
    iResp_expected = resp;
    iStart         = 1'b1;
    acc            = cyc + 1;
    for (int i = FB - 1; i >= 0; i--) sbBit.push_back(frame[i]);
    tick();
    iStart = 1'b0;
  endtask

  task automatic push_done(input logic [RB-1:0] r, input logic t, input int c);
    done_t e;
    e.resp  = r;
    e.tout  = t;
    e.cycle = c;
    sbDone.push_back(e);
  endtask

  task automatic wait_idle();
    int n = 0;
    while (oBusy && n < 500) begin
      tick();
      n++;
    end
    check("idle_reached", oBusy, 0);
    tick();
  endtask

  // Drives 0 during TURN (must be ignored), idles w WAIT_RESP cycles, then start bit and response.
  task automatic drive_resp(input int acc, input int w, input logic [RB-1:0] r,
                            input int stallAt, input int stallLen);
    int e;
    wait_cyc(acc + 38);
    iSerial = 1'b0;
    wait_cyc(acc + 40);
    iSerial = 1'b1;
    e = acc + 41 + w;
    wait_cyc(e - 1);
    iSerial = 1'b0;
    for (int i = 0; i < RB; i++) begin
      if (i == stallAt) begin
        for (int k = 0; k < stallLen; k++) begin
          wait_cyc(e);
          iEnable = 1'b0;
          iSerial = k[0];
          e++;
        end
      end
      wait_cyc(e);
      iEnable = 1'b1;
      iSerial = r[RB-1-i];
      e++;
    end
    wait_cyc(e);
    iSerial = 1'b1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
    $fatal(1, "watchdog expired");
  end

  initial begin
    int acc;
    iReset = 1'b0; iEnable = 1'b1; iStart = 1'b0; iResp_expected = 1'b0;
    iParallel = '0; iSerial = 1'b1;
    repeat (3) tick();
    check("rst_oe", oOutput_enable, 0);
    check("rst_serial", oSerial, 1);
    check("rst_busy", oBusy, 0);
    check("rst_complete", oComplete, 0);
    check("rst_timeout", oTimeout, 0);
    check("rst_response", oResponse, 0);
    iReset = 1'b1;
    repeat (2) tick();

    // Send-only frame: completion visible 38 edges after the accepting edge.
    start_cmd(38'h2A_5555_AAAA, 1'b0, acc);
    push_done(32'h0, 1'b0, acc + 38);
    wait_idle();

    // Response after 5 idle WAIT_RESP cycles.
    start_cmd(38'h05_1234_5678, 1'b1, acc);
    push_done(32'hDEAD_BEEF, 1'b0, acc + 41 + 5 + 32);
    drive_resp(acc, 5, 32'hDEAD_BEEF, RB, 0);
    wait_idle();

    // No start bit: timeout after 64 WAIT_RESP cycles, response kept.
    iSerial = 1'b1;
    start_cmd(38'h11_0000_FFFF, 1'b1, acc);
    push_done(32'hDEAD_BEEF, 1'b1, acc + 104);
    wait_idle();

    // Asynchronous reset while bit 20 is on the line.
    start_cmd(38'h3C_C3C3_5A5A, 1'b0, acc);
    wait_cyc(acc + 17);
    @(posedge iSD_clock);
    #2 iReset = 1'b0;
    #1;
    check("async_rst_oe", oOutput_enable, 0);
    check("async_rst_serial", oSerial, 1);
    check("async_rst_busy", oBusy, 0);
    check("async_rst_timeout", oTimeout, 0);
    check("async_rst_response", oResponse, 0);
    check("bits_sent_before_rst", sbBit.size(), 20);
    sbBit.delete();
    tick();
    iReset = 1'b1;
    repeat (2) tick();
    start_cmd(38'h3F_0F0F_1234, 1'b0, acc);
    push_done(32'h0, 1'b0, acc + 38);
    wait_idle();

    // 10-cycle stall in the middle of RECEIVE with noise on the line.
    start_cmd(38'h00_FEDC_BA98, 1'b1, acc);
    push_done(32'hA5C3_0F96, 1'b0, acc + 41 + 3 + 32 + 10);
    drive_resp(acc, 3, 32'hA5C3_0F96, 13, 10);
    wait_idle();

    // Starts during SEND and in the DONE cycle are ignored.
    start_cmd(38'h15_A5A5_0F0F, 1'b0, acc);
    push_done(32'hA5C3_0F96, 1'b0, acc + 38);
    wait_cyc(acc + 10);
    iStart = 1'b1; iResp_expected = 1'b1; iParallel = 38'h0;
    tick();
    iStart = 1'b0;
    wait_cyc(acc + 38);
    iStart = 1'b1;
    wait_cyc(acc + 39);
    iStart = 1'b0;
    wait_cyc(acc + 41);
    check("no_restart_busy", oBusy, 0);
    check("no_restart_oe", oOutput_enable, 0);

    repeat (3) tick();
    check("done_queue_empty", sbDone.size(), 0);
    check("bit_queue_empty", sbBit.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end

endmodule
